alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_op_decode.sv | 55 +++++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: ALU control codes, ALUOp groups and FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_MUL  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLL  = 3'b110;
    localparam logic [2:0] ALU_SRA  = 3'b111;

    localparam logic [1:0] ALUOP_REG = 2'b00;
    localparam logic [1:0] ALUOP_IMM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct decoder producing the shared-ALU control code.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [9:0] funct,
    output logic [2:0] ctrl,
    output logic       is_mul,
    output logic       illegal
);

    logic [6:0] funct7;
    logic [2:0] funct3;

    assign funct7 = funct[9:3];
    assign funct3 = funct[2:0];

    // Map the {ALUOp, funct7, funct3} triple onto an ALU code; anything unlisted is illegal.
    always_comb begin
        ctrl    = ALU_NONE;
        illegal = 1'b1;
        case (aluop)
            ALUOP_REG: begin
                case (funct3)
                    3'b001: begin ctrl = ALU_SLL; illegal = 1'b0; end
                    3'b100: begin ctrl = ALU_XOR; illegal = 1'b0; end
                    3'b111: begin ctrl = ALU_AND; illegal = 1'b0; end
                    3'b000: begin
                        case (funct7)
                            7'b0000000: begin ctrl = ALU_ADD; illegal = 1'b0; end
                            7'b0100000: begin ctrl = ALU_SUB; illegal = 1'b0; end
                            7'b0000001: begin ctrl = ALU_MUL; illegal = 1'b0; end
                            default:    begin ctrl = ALU_NONE; illegal = 1'b1; end
                        endcase
                    end
                    default: begin ctrl = ALU_NONE; illegal = 1'b1; end
                endcase
            end
            ALUOP_IMM: begin
                case (funct3)
                    3'b000:  begin ctrl = ALU_ADD; illegal = 1'b0; end
                    3'b101:  begin ctrl = ALU_SRA; illegal = 1'b0; end
                    default: begin ctrl = ALU_NONE; illegal = 1'b1; end
                endcase
            end
            default: begin
                ctrl    = ALU_NONE;
                illegal = 1'b1;
            end
        endcase
    end

    assign is_mul = (ctrl == ALU_MUL);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// One operation is in flight at a time: IDLE grants, EXEC drives the ALU, RESP holds the result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [19:0] req_funct_i,
    input  logic [3:0]  req_aluop_i,
    input  logic [63:0] req_a_i,
    input  logic [63:0] req_b_i,
    output logic [2:0]  alu_ctrl_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o
);

    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    state_t      state;
    logic        ptr;
    logic [3:0]  exec_cnt;

    logic        grant_any;
    logic        grant_idx;
    logic [9:0]  sel_funct;
    logic [1:0]  sel_aluop;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    logic [2:0]  dec_ctrl;
    logic        dec_is_mul;
    logic        dec_illegal;

    // Grant selection: a lone requester wins, a tie goes to the round-robin pointer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
        if (state == ST_IDLE && !rst_i) begin
            case (req_valid_i)
                2'b01:   begin grant_any = 1'b1; grant_idx = 1'b0; end
                2'b10:   begin grant_any = 1'b1; grant_idx = 1'b1; end
                2'b11:   begin grant_any = 1'b1; grant_idx = ptr;  end
                default: begin grant_any = 1'b0; grant_idx = 1'b0; end
            endcase
        end
    end

    // Ready is only offered to the requester that would be accepted this cycle,
    // so valid&ready reduces to grant_any.
    assign req_ready_o = grant_any ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

    assign sel_funct = grant_idx ? req_funct_i[19:10] : req_funct_i[9:0];
    assign sel_aluop = grant_idx ? req_aluop_i[3:2]   : req_aluop_i[1:0];
    assign sel_a     = grant_idx ? req_a_i[63:32]     : req_a_i[31:0];
    assign sel_b     = grant_idx ? req_b_i[63:32]     : req_b_i[31:0];

    alu_op_decode u_decode (
        .aluop   (sel_aluop),
        .funct   (sel_funct),
        .ctrl    (dec_ctrl),
        .is_mul  (dec_is_mul),
        .illegal (dec_illegal)
    );

    // Control FSM with registered ALU drive and response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            ptr         <= 1'b0;
            exec_cnt    <= 4'd0;
            alu_ctrl_o  <= ALU_NONE;
            alu_a_o     <= 32'd0;
            alu_b_o     <= 32'd0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_data_o  <= 32'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        ptr      <= ~grant_idx;
                        alu_a_o  <= sel_a;
                        alu_b_o  <= sel_b;
                        rsp_id_o <= grant_idx;
                        if (dec_illegal) begin
                            // Unmapped op: skip the ALU entirely and report an error.
                            state       <= ST_RESP;
                            alu_ctrl_o  <= ALU_NONE;
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= 32'd0;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            state      <= ST_EXEC;
                            alu_ctrl_o <= dec_ctrl;
                            exec_cnt   <= dec_is_mul ? MUL_LAST : 4'd0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        state       <= ST_RESP;
                        alu_ctrl_o  <= ALU_NONE;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= alu_result_i;
                        rsp_err_o   <= 1'b0;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state       <= ST_IDLE;
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
